lcd_text_sequencer: RTL

LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

---
 rtl/lcd_text_sequencer_if.sv | 23 ++
 rtl/lcd_text_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_sequencer_if.sv
// Host character channel plus LCD-writer strobe channel of the text sequencer.
// The master drives the host side; the slave is the sequencer itself.
interface lcd_text_sequencer_if;
  logic       iChar_Valid;
  logic [7:0] iChar;
  logic       oChar_Ready;
  logic       iClear;
  logic       iRefresh;
  logic       oWrite_Enabled;
  logic [7:0] oData;
  logic       oIsCommand;
  logic       oBusy;

  modport master (
    output iChar_Valid, iChar, iClear, iRefresh,
    input  oChar_Ready, oWrite_Enabled, oData, oIsCommand, oBusy
  );

  modport slave (
    input  iChar_Valid, iChar, iClear, iRefresh,
    output oChar_Ready, oWrite_Enabled, oData, oIsCommand, oBusy
  );
endinterface

// File: rtl/lcd_text_sequencer.sv
// Buffers host characters in a 32-entry screen image and replays the whole
// screen (address + 16 chars per line) to an LCD writer whenever it is dirty.
module lcd_text_sequencer #(
  parameter int unsigned INIT_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES  = 2200
) (
  input logic                 Clock,
  input logic                 Reset,
  lcd_text_sequencer_if.slave bus
);

  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  // GAP holds GAP_CYCLES-1 cycles so the strobe-to-strobe distance is GAP_CYCLES.
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 2);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_INIT_WAIT,
    S_IDLE,
    S_ADDR,
    S_CHAR,
    S_GAP
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [7:0]        screen [32];
  logic [4:0]        ptr_q;
  logic [4:0]        clr_idx_q;
  logic              line_q;
  logic [3:0]        col_q;
  logic              dirty_q;
  logic              from_reset_q;
  logic              after_addr_q;
  logic [INIT_W-1:0] init_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [7:0]        data_q;
  logic              cmd_q;

  logic              ready;
  logic              accept;
  logic              gap_done;
  logic              pass_start;
  logic              strobe;
  logic              strobe_cmd;
  logic [7:0]        strobe_dat;

  assign ready      = (state_q != S_CLEAR);
  // A clear in IDLE takes priority over a character offered in the same cycle.
  assign accept     = bus.iChar_Valid && ready && !(state_q == S_IDLE && bus.iClear);
  assign gap_done   = (gap_cnt_q == GAP_LAST);
  assign pass_start = (state_q == S_IDLE) && !bus.iClear && dirty_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    strobe     = 1'b0;
    strobe_cmd = 1'b0;
    strobe_dat = 8'h00;
    case (state_q)
      S_CLEAR: begin
        if (clr_idx_q == 5'd31) begin
          state_d = from_reset_q ? S_INIT_WAIT : S_IDLE;
        end
      end
      S_INIT_WAIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.iClear) begin
          state_d = S_CLEAR;
        end else if (dirty_q) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        strobe     = 1'b1;
        strobe_cmd = 1'b1;
        strobe_dat = line_q ? 8'hC0 : 8'h80;
        state_d    = S_GAP;
      end
      S_CHAR: begin
        // Combinational read sees the pre-edge contents, so a same-cycle
        // host write to this entry shows up only on the next pass.
        strobe     = 1'b1;
        strobe_dat = screen[{line_q, col_q}];
        state_d    = S_GAP;
      end
      S_GAP: begin
        if (gap_done) begin
          if (after_addr_q) begin
            state_d = S_CHAR;
          end else if (col_q == 4'd15) begin
            state_d = line_q ? S_IDLE : S_ADDR;
          end else begin
            state_d = S_CHAR;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr_q        <= 5'd0;
      clr_idx_q    <= 5'd0;
      line_q       <= 1'b0;
      col_q        <= 4'd0;
      dirty_q      <= 1'b0;
      from_reset_q <= 1'b1;
      after_addr_q <= 1'b0;
      init_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      data_q       <= 8'h00;
      cmd_q        <= 1'b0;
    end else begin
      if (strobe) begin
        data_q <= strobe_dat;
        cmd_q  <= strobe_cmd;
      end

      if (state_q == S_CLEAR) begin
        ptr_q     <= 5'd0;
        clr_idx_q <= clr_idx_q + 5'd1;
      end else if (accept) begin
        ptr_q <= ptr_q + 5'd1;
      end

      // Starting a pass consumes dirty even if a character lands in the same
      // cycle: that character is already in the buffer before any read.
      if (state_q == S_CLEAR) begin
        dirty_q <= 1'b1;
      end else if (pass_start) begin
        dirty_q <= 1'b0;
      end else if (accept || bus.iRefresh) begin
        dirty_q <= 1'b1;
      end

      if (state_q == S_IDLE && bus.iClear) begin
        from_reset_q <= 1'b0;
      end

      if (state_q == S_INIT_WAIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end else begin
        init_cnt_q <= '0;
      end

      if (state_q == S_GAP) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end else begin
        gap_cnt_q <= '0;
      end

      if (state_q == S_ADDR) begin
        after_addr_q <= 1'b1;
      end else if (state_q == S_CHAR) begin
        after_addr_q <= 1'b0;
      end

      if (pass_start) begin
        line_q <= 1'b0;
        col_q  <= 4'd0;
      end else if (state_q == S_GAP && gap_done && !after_addr_q) begin
        col_q <= col_q + 4'd1;
        if (col_q == 4'd15) begin
          line_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state_q == S_CLEAR) begin
        screen[clr_idx_q] <= 8'h20;
      end else if (accept) begin
        screen[ptr_q] <= bus.iChar;
      end
    end
  end

  assign bus.oChar_Ready    = ready;
  assign bus.oBusy          = (state_q != S_IDLE);
  assign bus.oWrite_Enabled = strobe;
  assign bus.oData          = strobe ? strobe_dat : data_q;
  assign bus.oIsCommand     = strobe ? strobe_cmd : cmd_q;

endmodule
